// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - word-level request front end for a J-K master-slave state register
//
// Purpose: accepts hold/load/toggle/clear requests on a valid/ready handshake,
// derives the minimal per-bit J/K excitation, and applies it as a master
// capture followed by a slave transfer.
//
// Optional feature: define JK_EXCITE_PARITY_EN to add q_par, the registered
// XOR-reduce of Q.
//
// Ports:
//   Clk       clock, rising edge
//   Rst       asynchronous active-low reset
//   in_valid  request valid
//   in_ready  request can be accepted (IDLE and out of reset)
//   op        00 hold, 01 load, 10 toggle-mask, 11 clear
//   data      load target or toggle mask
//   J, K      registered excitation of the last accepted request
//   Q, Qb     slave state and its complement
//   done      one-cycle pulse when Q has been updated
//   q_par     (JK_EXCITE_PARITY_EN only) parity of Q
module jk_excite_driver #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             done
`ifdef JK_EXCITE_PARITY_EN
    ,
    output logic             q_par
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MASTER = 2'd1,
        SLAVE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             accept;

    // Ready is gated by Rst so the handshake is refused while reset is held.
    assign in_ready = (state_q == IDLE) && Rst;
    assign accept   = in_valid && in_ready;
    assign Qb       = ~Q;

    // Minimal excitation: bits that already hold the target value get J=K=0.
    always_comb begin
        j_next = '0;
        k_next = '0;
        case (op)
            2'b01: begin
                j_next = data & ~Q;
                k_next = ~data & Q;
            end
            2'b10: begin
                j_next = data;
                k_next = data;
            end
            2'b11: begin
                j_next = '0;
                k_next = Q;
            end
            default: begin
                j_next = '0;
                k_next = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MASTER;
            MASTER:  state_d = SLAVE;
            SLAVE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            J        <= '0;
            K        <= '0;
            master_q <= '0;
            Q        <= '0;
            done     <= 1'b0;
`ifdef JK_EXCITE_PARITY_EN
            q_par    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        J <= j_next;
                        K <= k_next;
                    end
                end
                MASTER: begin
                    // Characteristic equation Q+ = J~Q | ~KQ, evaluated per bit.
                    master_q <= (J & ~Q) | (~K & Q);
                end
                SLAVE: begin
                    Q    <= master_q;
                    done <= 1'b1;
`ifdef JK_EXCITE_PARITY_EN
                    q_par <= ^master_q;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - directed self-checking bench for jk_excite_driver
module tb_jk_excite_driver;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] J;
    logic [7:0] K;
    logic [7:0] Q;
    logic [7:0] Qb;
    logic       done;
`ifdef JK_EXCITE_PARITY_EN
    logic       q_par;
`endif

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    jk_excite_driver #(.WIDTH(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .data     (data),
        .J        (J),
        .K        (K),
        .Q        (Q),
        .Qb       (Qb),
        .done     (done)
`ifdef JK_EXCITE_PARITY_EN
        ,
        .q_par    (q_par)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present a request and let it be accepted at the next edge (E0).
    task automatic req(input logic [1:0] o, input logic [7:0] d);
        in_valid = 1'b1;
        op       = o;
        data     = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        Rst      = 1'b0;
        in_valid = 1'b0;
        op       = 2'b00;
        data     = 8'h00;
        step();
        step();
        chk("rst_Q", Q, 8'h00);
        chk("rst_Qb", Qb, 8'hFF);
        chk("rst_J", J, 8'h00);
        chk("rst_K", K, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
`ifdef JK_EXCITE_PARITY_EN
        chk("rst_q_par", q_par, 1'b0);
`endif
        Rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // 1: reset asserted during MASTER after a load of 0xFF
        req(2'b01, 8'hFF);
        chk("t1_J", J, 8'hFF);
        chk("t1_K", K, 8'h00);
        #2;
        Rst = 1'b0;
        #1;
        chk("t1_async_Q", Q, 8'h00);
        chk("t1_async_Qb", Qb, 8'hFF);
        chk("t1_async_J", J, 8'h00);
        chk("t1_async_K", K, 8'h00);
        chk("t1_async_in_ready", in_ready, 1'b0);
        chk("t1_async_done", done, 1'b0);
        step();
        Rst = 1'b1;
        #1;
        chk("t1_rel_in_ready", in_ready, 1'b1);
        step();
        step();
        chk("t1_rel_Q", Q, 8'h00);
        chk("t1_rel_done", done, 1'b0);

        // 2: load 0xA5 from 0x00
        req(2'b01, 8'hA5);
        chk("t2_E0_J", J, 8'hA5);
        chk("t2_E0_K", K, 8'h00);
        chk("t2_E0_in_ready", in_ready, 1'b0);
        chk("t2_E0_done", done, 1'b0);
        step();
        chk("t2_E1_Q", Q, 8'h00);
        chk("t2_E1_done", done, 1'b0);
`ifdef JK_EXCITE_PARITY_EN
        chk("t6_E1_q_par_a5", q_par, 1'b0);
`endif
        step();
        chk("t2_E2_Q", Q, 8'hA5);
        chk("t2_E2_Qb", Qb, 8'h5A);
        chk("t2_E2_done", done, 1'b1);
`ifdef JK_EXCITE_PARITY_EN
        chk("t6_E2_q_par_a5", q_par, 1'b0);
`endif
        step();
        chk("t2_E3_done", done, 1'b0);
        chk("t2_E3_in_ready", in_ready, 1'b1);

        // 3: toggle 0x0F
        req(2'b10, 8'h0F);
        chk("t3_J", J, 8'h0F);
        chk("t3_K", K, 8'h0F);
        step();
        step();
        chk("t3_Q", Q, 8'hAA);
        chk("t3_done", done, 1'b1);
        step();

        // 4: load 0x3C from 0xAA
        req(2'b01, 8'h3C);
        chk("t4_J", J, 8'h14);
        chk("t4_K", K, 8'h82);
        step();
        chk("t4_E1_Q", Q, 8'hAA);
        step();
        chk("t4_Q", Q, 8'h3C);
        chk("t4_Qb", Qb, 8'hC3);
        step();

        // 5: back-to-back hold then clear with in_valid held high
        done_cnt = 0;
        in_valid = 1'b1;
        op       = 2'b00;
        data     = 8'h00;
        step();                              // E0: hold accepted
        done_cnt += int'(done);
        chk("t5_hold_J", J, 8'h00);
        chk("t5_hold_K", K, 8'h00);
        data = 8'hFF;                        // ignored while in MASTER
        step();                              // E1
        done_cnt += int'(done);
        op = 2'b11;                          // clear presented during SLAVE
        step();                              // E2
        done_cnt += int'(done);
        chk("t5_hold_Q", Q, 8'h3C);
        chk("t5_hold_done", done, 1'b1);
        chk("t5_E2_in_ready", in_ready, 1'b1);
        step();                              // E3: clear accepted
        done_cnt += int'(done);
        in_valid = 1'b0;
        chk("t5_clr_J", J, 8'h00);
        chk("t5_clr_K", K, 8'h3C);
        chk("t5_E3_in_ready", in_ready, 1'b0);
        step();                              // E4
        done_cnt += int'(done);
        chk("t5_E4_Q", Q, 8'h3C);
        step();                              // E5
        done_cnt += int'(done);
        chk("t5_clr_Q", Q, 8'h00);
        chk("t5_clr_Qb", Qb, 8'hFF);
        step();                              // E6
        done_cnt += int'(done);
        chk("t5_done_pulses", done_cnt, 2);
        chk("t5_E6_in_ready", in_ready, 1'b1);

`ifdef JK_EXCITE_PARITY_EN
        // 6: parity follows Q on the same edge
        req(2'b01, 8'hA5);
        step();
        step();
        chk("t6_Q_a5", Q, 8'hA5);
        chk("t6_q_par_a5", q_par, 1'b0);
        step();
        req(2'b01, 8'h07);
        step();
        chk("t6_E1_q_par_07", q_par, 1'b0);
        step();
        chk("t6_Q_07", Q, 8'h07);
        chk("t6_q_par_07", q_par, 1'b1);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
